// File: rtl/demo_seq_pkg.sv
// Shared types, widths and the default scene script for the demo sequencer.
package demo_seq_pkg;

  localparam int SCENE_W = 3;
  localparam int FADE_W  = 6;
  localparam int HOLD_W  = 10;

  localparam logic [FADE_W-1:0] FADE_MAX = 6'd63;

  typedef enum logic [1:0] {
    ST_FADE_IN,
    ST_HOLD,
    ST_FADE_OUT,
    ST_SWITCH
  } seq_state_t;

  typedef struct packed {
    logic plane;
    logic scroll;
    logic colorbar;
    logic lfsr;
  } scene_flags_t;

  typedef struct packed {
    logic [HOLD_W-1:0] hold_frames;
    scene_flags_t      flags;
  } script_entry_t;

  // Default script: hold length in frames plus effect flags per scene.
  function automatic script_entry_t script_lookup(input logic [SCENE_W-1:0] idx);
    script_entry_t e;
    case (idx)
      3'd0:    e = '{hold_frames: 10'd300, flags: '{plane: 1'b0, scroll: 1'b1, colorbar: 1'b1, lfsr: 1'b0}};
      3'd1:    e = '{hold_frames: 10'd600, flags: '{plane: 1'b1, scroll: 1'b1, colorbar: 1'b0, lfsr: 1'b0}};
      3'd2:    e = '{hold_frames: 10'd240, flags: '{plane: 1'b0, scroll: 1'b0, colorbar: 1'b0, lfsr: 1'b1}};
      3'd3:    e = '{hold_frames: 10'd480, flags: '{plane: 1'b1, scroll: 1'b1, colorbar: 1'b0, lfsr: 1'b1}};
      default: e = '{hold_frames: 10'd60,  flags: '{plane: 1'b0, scroll: 1'b0, colorbar: 1'b0, lfsr: 1'b0}};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/demo_sequencer_rom.sv
// Combinational script ROM: scene index to hold length and effect flags.
module demo_script_rom
  import demo_seq_pkg::*;
(
  input  logic [SCENE_W-1:0] scene,
  output logic [HOLD_W-1:0]  hold_frames,
  output scene_flags_t       flags
);

  script_entry_t entry;

  always_comb begin
    entry       = script_lookup(scene);
    hold_frames = entry.hold_frames;
    flags       = entry.flags;
  end

endmodule

// File: rtl/demo_sequencer.sv
// Frame-stepped scene scheduler: fade-in / hold / fade-out / switch per scene,
// driving brightness and effect enables into the pixel pipeline.
module demo_sequencer
  import demo_seq_pkg::*;
#(
  parameter int NUM_SCENES = 4,
  parameter int FADE_STEP  = 2,
  parameter int LOOP       = 1
) (
  input  logic               clk48,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               skip,
  input  logic               pause,
  output logic [SCENE_W-1:0] scene,
  output logic [FADE_W-1:0]  fade,
  output logic               plane_en,
  output logic               scroll_en,
  output logic               colorbar_en,
  output logic               dither_lfsr,
  output logic               scene_start
);

  localparam logic [SCENE_W-1:0] LAST_SCENE = SCENE_W'(NUM_SCENES - 1);
  localparam logic [FADE_W-1:0]  STEP       = FADE_W'(FADE_STEP);
  localparam script_entry_t      SCENE0     = script_lookup('0);

  seq_state_t         state_q, state_d;
  logic [SCENE_W-1:0] scene_q, scene_d;
  logic [FADE_W-1:0]  fade_q, fade_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               skip_q, skip_d;
  scene_flags_t       flags_q, flags_d;
  logic               start_q, start_d;

  logic [SCENE_W-1:0] next_scene, rom_addr;
  logic [HOLD_W-1:0]  rom_hold;
  scene_flags_t       rom_flags;
  logic [FADE_W:0]    fade_sum;
  logic [FADE_W-1:0]  fade_inc, fade_dec;
  logic               parked, skip_now;

  // In SWITCH the ROM is addressed with the upcoming scene so its flags load
  // together with the index; otherwise it serves the current scene's hold.
  assign next_scene = (scene_q == LAST_SCENE) ? '0 : scene_q + 1'b1;
  assign rom_addr   = (state_q == ST_SWITCH) ? next_scene : scene_q;

  demo_script_rom u_rom (
    .scene       (rom_addr),
    .hold_frames (rom_hold),
    .flags       (rom_flags)
  );

  assign fade_sum = {1'b0, fade_q} + {1'b0, STEP};
  assign fade_inc = (fade_sum > {1'b0, FADE_MAX}) ? FADE_MAX : fade_sum[FADE_W-1:0];
  assign fade_dec = (fade_q <= STEP) ? '0 : fade_q - STEP;

  // Non-looping script freezes in the last scene; skips there are dropped.
  assign parked   = (LOOP == 0) && (scene_q == LAST_SCENE);
  assign skip_now = skip | skip_q;

  always_comb begin
    state_d = state_q;
    scene_d = scene_q;
    fade_d  = fade_q;
    hold_d  = hold_q;
    flags_d = flags_q;
    skip_d  = skip_now;
    start_d = 1'b0;
    if (frame_start) begin
      skip_d = 1'b0;
      unique case (state_q)
        ST_FADE_IN: begin
          if (skip_now && !parked) begin
            state_d = ST_FADE_OUT;
          end else begin
            fade_d = fade_inc;
            if (fade_inc == FADE_MAX) begin
              state_d = ST_HOLD;
              hold_d  = rom_hold;
            end
          end
        end
        ST_HOLD: begin
          if (skip_now && !parked) begin
            state_d = ST_FADE_OUT;
          end else if (hold_q == '0) begin
            if (!parked) state_d = ST_FADE_OUT;
          end else if (!pause) begin
            hold_d = hold_q - 1'b1;
          end
        end
        ST_FADE_OUT: begin
          fade_d = fade_dec;
          if (fade_dec == '0) state_d = ST_SWITCH;
        end
        ST_SWITCH: begin
          scene_d = next_scene;
          flags_d = rom_flags;
          start_d = 1'b1;
          state_d = ST_FADE_IN;
        end
        default: state_d = ST_FADE_IN;
      endcase
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state_q <= ST_FADE_IN;
      scene_q <= '0;
      fade_q  <= '0;
      hold_q  <= '0;
      skip_q  <= 1'b0;
      flags_q <= SCENE0.flags;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scene_q <= scene_d;
      fade_q  <= fade_d;
      hold_q  <= hold_d;
      skip_q  <= skip_d;
      flags_q <= flags_d;
      start_q <= start_d;
    end
  end

  assign scene       = scene_q;
  assign fade        = fade_q;
  assign plane_en    = flags_q.plane;
  assign scroll_en   = flags_q.scroll;
  assign colorbar_en = flags_q.colorbar;
  assign dither_lfsr = flags_q.lfsr;
  assign scene_start = start_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// Directed bench: default sequencer, a non-looping copy and a FADE_STEP=63 copy
// share one stimulus stream; each scenario checks the relevant instance.
module tb_demo_sequencer;

  logic clk48 = 1'b0;
  logic rst = 1'b1, frame_start = 1'b0, skip = 1'b0, pause = 1'b0;

  logic [2:0] scene_a, scene_n, scene_f;
  logic [5:0] fade_a, fade_n, fade_f;
  logic plane_a, scroll_a, cbar_a, lfsr_a, sstart_a;
  logic plane_n, scroll_n, cbar_n, lfsr_n, sstart_n;
  logic plane_f, scroll_f, cbar_f, lfsr_f, sstart_f;

  int n_pass = 0, n_total = 0, ss_cnt = 0;

  always #5 clk48 = ~clk48;

  demo_sequencer #(.NUM_SCENES(4), .FADE_STEP(2), .LOOP(1)) dut (
    .clk48(clk48), .rst(rst), .frame_start(frame_start), .skip(skip), .pause(pause),
    .scene(scene_a), .fade(fade_a), .plane_en(plane_a), .scroll_en(scroll_a),
    .colorbar_en(cbar_a), .dither_lfsr(lfsr_a), .scene_start(sstart_a));

  demo_sequencer #(.NUM_SCENES(4), .FADE_STEP(2), .LOOP(0)) dut_nl (
    .clk48(clk48), .rst(rst), .frame_start(frame_start), .skip(skip), .pause(pause),
    .scene(scene_n), .fade(fade_n), .plane_en(plane_n), .scroll_en(scroll_n),
    .colorbar_en(cbar_n), .dither_lfsr(lfsr_n), .scene_start(sstart_n));

  demo_sequencer #(.NUM_SCENES(4), .FADE_STEP(63), .LOOP(1)) dut_fs (
    .clk48(clk48), .rst(rst), .frame_start(frame_start), .skip(skip), .pause(pause),
    .scene(scene_f), .fade(fade_f), .plane_en(plane_f), .scroll_en(scroll_f),
    .colorbar_en(cbar_f), .dither_lfsr(lfsr_f), .scene_start(sstart_f));

  always @(negedge clk48) if (sstart_a === 1'b1) ss_cnt++;

  // Frame pulse every third cycle; returns one negedge after the sampling edge.
  task automatic frame(input logic sk);
    @(negedge clk48); @(negedge clk48);
    frame_start = 1'b1; skip = sk;
    @(negedge clk48);
    frame_start = 1'b0; skip = 1'b0;
  endtask

  task automatic pulse_skip();
    @(negedge clk48); skip = 1'b1;
    @(negedge clk48); skip = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk48);
    rst = 1'b1; frame_start = 1'b0; skip = 1'b0; pause = 1'b0;
    @(negedge clk48);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk48);
    rst = 1'b0;
    @(negedge clk48);
    n_total++;
    if ({scene_a, fade_a, plane_a, scroll_a, cbar_a, lfsr_a, sstart_a} !== {3'd0, 6'd0, 5'b01100}) begin
      $display("FAIL reset_init: got scene=%0d fade=%0d flags=%b%b%b%b ss=%b, want 0 0 0110 0",
               scene_a, fade_a, plane_a, scroll_a, cbar_a, lfsr_a, sstart_a);
    end else n_pass++;
    // Walk to scene 2 with skips, fade in, sit in HOLD, then reset.
    for (int f = 1; f <= 6; f++) frame(f % 3 == 1);
    n_total++;
    if (scene_a !== 3'd2 || lfsr_a !== 1'b1) $display("FAIL reset_reach_s2: scene=%0d lfsr=%b, want 2 1", scene_a, lfsr_a);
    else n_pass++;
    for (int f = 0; f < 40; f++) frame(1'b0);
    n_total++;
    if (fade_a !== 6'd63) $display("FAIL reset_hold_fade: got %0d want 63", fade_a);
    else n_pass++;
    do_reset();
    n_total++;
    if ({scene_a, fade_a, plane_a, scroll_a, cbar_a, lfsr_a, sstart_a} !== {3'd0, 6'd0, 5'b01100}) begin
      $display("FAIL reset_mid_hold: got scene=%0d fade=%0d flags=%b%b%b%b ss=%b, want 0 0 0110 0",
               scene_a, fade_a, plane_a, scroll_a, cbar_a, lfsr_a, sstart_a);
    end else n_pass++;
    frame(1'b0);
    n_total++;
    if (fade_a !== 6'd2 || sstart_a !== 1'b0) $display("FAIL reset_restart: fade=%0d ss=%b, want 2 0", fade_a, sstart_a);
    else n_pass++;
  endtask

  task automatic test_scene0();
    do_reset();
    ss_cnt = 0;
    for (int n = 1; n <= 366; n++) begin
      frame(1'b0);
      if (n == 31 || n == 32 || n == 333 || n == 334 || n == 364 || n == 365) begin
        logic [5:0] exp;
        exp = (n == 31) ? 6'd62 : (n == 32 || n == 333) ? 6'd63 :
              (n == 334) ? 6'd61 : (n == 364) ? 6'd1 : 6'd0;
        n_total++;
        if (fade_a !== exp || scene_a !== 3'd0) $display("FAIL scene0_fade_f%0d: fade=%0d scene=%0d, want %0d 0", n, fade_a, scene_a, exp);
        else n_pass++;
      end
      if (n == 366) begin
        n_total++;
        if ({scene_a, plane_a, scroll_a, cbar_a, lfsr_a, sstart_a} !== {3'd1, 5'b11001})
          $display("FAIL scene0_switch: scene=%0d flags=%b%b%b%b ss=%b, want 1 1100 1",
                   scene_a, plane_a, scroll_a, cbar_a, lfsr_a, sstart_a);
        else n_pass++;
      end
    end
    repeat (2) @(negedge clk48);
    n_total++;
    if (ss_cnt !== 1 || sstart_a !== 1'b0) $display("FAIL scene0_pulse: count=%0d now=%b, want 1 0", ss_cnt, sstart_a);
    else n_pass++;
  endtask

  task automatic test_skip_pause();
    do_reset();
    for (int f = 0; f < 232; f++) frame(1'b0);
    pause = 1'b1;
    for (int f = 0; f < 150; f++) frame(1'b0);
    n_total++;
    if (fade_a !== 6'd63) $display("FAIL pause_freeze: fade=%0d want 63", fade_a);
    else n_pass++;
    pulse_skip();
    frame(1'b0);
    n_total++;
    if (fade_a !== 6'd63) $display("FAIL skip_enter_fo: fade=%0d want 63", fade_a);
    else n_pass++;
    frame(1'b0);
    n_total++;
    if (fade_a !== 6'd61) $display("FAIL skip_first_fo: fade=%0d want 61", fade_a);
    else n_pass++;
    pause = 1'b0;
  endtask

  task automatic test_skip_coincident();
    do_reset();
    for (int f = 0; f < 20; f++) frame(1'b0);
    n_total++;
    if (fade_a !== 6'd40) $display("FAIL coinc_pre: fade=%0d want 40", fade_a);
    else n_pass++;
    frame(1'b1);
    n_total++;
    if (fade_a !== 6'd40) $display("FAIL coinc_hold: fade=%0d want 40", fade_a);
    else n_pass++;
    pulse_skip();
    frame(1'b0);
    n_total++;
    if (fade_a !== 6'd38) $display("FAIL coinc_fo: fade=%0d want 38", fade_a);
    else n_pass++;
    for (int f = 0; f < 19; f++) frame(1'b0);
    n_total++;
    if (fade_a !== 6'd0 || scene_a !== 3'd0) $display("FAIL coinc_black: fade=%0d scene=%0d want 0 0", fade_a, scene_a);
    else n_pass++;
    frame(1'b0);
    n_total++;
    if (scene_a !== 3'd1 || sstart_a !== 1'b1) $display("FAIL coinc_switch: scene=%0d ss=%b want 1 1", scene_a, sstart_a);
    else n_pass++;
    frame(1'b0);
    n_total++;
    if (fade_a !== 6'd2) $display("FAIL coinc_stale_skip: fade=%0d want 2", fade_a);
    else n_pass++;
  endtask

  task automatic test_wrap_and_park();
    do_reset();
    for (int f = 1; f <= 12; f++) begin
      frame(f % 3 == 1);
      if (f == 9) begin
        n_total++;
        if ({scene_a, plane_a, scroll_a, cbar_a, lfsr_a} !== {3'd3, 4'b1101})
          $display("FAIL wrap_s3: scene=%0d flags=%b%b%b%b want 3 1101", scene_a, plane_a, scroll_a, cbar_a, lfsr_a);
        else n_pass++;
      end
    end
    n_total++;
    if ({scene_a, cbar_a, sstart_a} !== {3'd0, 2'b11}) $display("FAIL wrap_s0: scene=%0d cbar=%b ss=%b want 0 1 1", scene_a, cbar_a, sstart_a);
    else n_pass++;
    for (int f = 13; f <= 700; f++) frame(1'b0);
    n_total++;
    if (scene_n !== 3'd3 || fade_n !== 6'd63) $display("FAIL park_hold: scene=%0d fade=%0d want 3 63", scene_n, fade_n);
    else n_pass++;
    frame(1'b1);
    pulse_skip();
    for (int f = 0; f < 5; f++) frame(1'b0);
    n_total++;
    if (scene_n !== 3'd3 || fade_n !== 6'd63) $display("FAIL park_skip: scene=%0d fade=%0d want 3 63", scene_n, fade_n);
    else n_pass++;
  endtask

  task automatic test_big_step();
    do_reset();
    frame(1'b0);
    n_total++;
    if (fade_f !== 6'd63) $display("FAIL step63_in: fade=%0d want 63", fade_f);
    else n_pass++;
    frame(1'b1);
    n_total++;
    if (fade_f !== 6'd63) $display("FAIL step63_skip: fade=%0d want 63", fade_f);
    else n_pass++;
    frame(1'b0);
    n_total++;
    if (fade_f !== 6'd0) $display("FAIL step63_out: fade=%0d want 0", fade_f);
    else n_pass++;
    frame(1'b0);
    n_total++;
    if (scene_f !== 3'd1 || plane_f !== 1'b1 || sstart_f !== 1'b1)
      $display("FAIL step63_switch: scene=%0d plane=%b ss=%b want 1 1 1", scene_f, plane_f, sstart_f);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_scene0();
    test_skip_pause();
    test_skip_coincident();
    test_wrap_and_park();
    test_big_step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
